// File: rtl/commit_trace_tx.sv
// commit_trace_tx: retirement-trace FIFO from core commit side to a valid/ready sink.
// Ports: commit_* in, trace_* out (FWFT head), fifo_cnt/full/drop_cnt status.
// Build option: define COMMIT_TRACE_SEQ_EN to add a per-commit sequence number.
module commit_trace_tx #(
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   commit_vld,
  input  logic [31:0]            commit_pc,
  input  logic [31:0]            commit_instr,
  input  logic                   commit_is_r,
  input  logic                   commit_is_i,
  input  logic [4:0]             commit_rd,
  input  logic [31:0]            commit_wr_data,
  output logic                   trace_vld,
  input  logic                   trace_rdy,
  output logic [31:0]            trace_pc,
  output logic [31:0]            trace_instr,
  output logic [31:0]            trace_wr_data,
  output logic [4:0]             trace_rd,
  output logic [1:0]             trace_kind,
  output logic [CW-1:0]          trace_seq,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   full,
  output logic [CW-1:0]          drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CW_ONE   = CW'(1);

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_wd_mem    [DEPTH];
  logic [4:0]    r_rd_mem    [DEPTH];
  logic [1:0]    r_kind_mem  [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic [CW-1:0] r_drop;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_kind;

  assign w_full  = (r_cnt == CNT_FULL);
  assign w_empty = (r_cnt == '0);
  // Push is judged on the pre-edge count: a same-cycle pop never frees room.
  assign w_push  = commit_vld & ~w_full & ~reset;
  assign w_pop   = ~w_empty & trace_rdy;
  // R wins when both type flags are set.
  assign w_kind  = {commit_is_i & ~commit_is_r, commit_is_r};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]    <= commit_pc;
      r_instr_mem[r_wptr] <= commit_instr;
      r_wd_mem[r_wptr]    <= commit_wr_data;
      r_rd_mem[r_wptr]    <= commit_rd;
      r_kind_mem[r_wptr]  <= w_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
      if (commit_vld && w_full && (r_drop != '1))
        r_drop <= r_drop + CW_ONE;
    end
  end

`ifdef COMMIT_TRACE_SEQ_EN
  logic [CW-1:0] r_seq;
  logic [CW-1:0] r_seq_mem [DEPTH];

  // Counts every commit, dropped or not, so drops show up as gaps.
  always_ff @(posedge clk) begin
    if (reset)
      r_seq <= '0;
    else if (commit_vld)
      r_seq <= r_seq + CW_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_seq_mem[r_wptr] <= r_seq;
  end

  assign trace_seq = w_empty ? '0 : r_seq_mem[r_rptr];
`else
  assign trace_seq = '0;
`endif

  assign trace_vld     = ~w_empty;
  assign trace_pc      = r_pc_mem[r_rptr];
  assign trace_instr   = r_instr_mem[r_rptr];
  assign trace_wr_data = r_wd_mem[r_rptr];
  assign trace_rd      = r_rd_mem[r_rptr];
  assign trace_kind    = r_kind_mem[r_rptr];
  assign fifo_cnt      = r_cnt;
  assign full          = w_full;
  assign drop_cnt      = r_drop;
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb_commit_trace_tx: directed stimulus, queue-based reference model,
// per-cycle compare plus literal checks.
module tb_commit_trace_tx;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
`ifdef COMMIT_TRACE_SEQ_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_vld;
  logic [31:0] commit_pc;
  logic [31:0] commit_instr;
  logic        commit_is_r;
  logic        commit_is_i;
  logic [4:0]  commit_rd;
  logic [31:0] commit_wr_data;
  logic        trace_vld;
  logic        trace_rdy;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [31:0] trace_wr_data;
  logic [4:0]  trace_rd;
  logic [1:0]  trace_kind;
  logic [CW-1:0] trace_seq;
  logic [3:0]  fifo_cnt;
  logic        full;
  logic [CW-1:0] drop_cnt;

  commit_trace_tx #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .commit_vld(commit_vld), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_is_r(commit_is_r),
    .commit_is_i(commit_is_i), .commit_rd(commit_rd),
    .commit_wr_data(commit_wr_data),
    .trace_vld(trace_vld), .trace_rdy(trace_rdy),
    .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_wr_data(trace_wr_data), .trace_rd(trace_rd),
    .trace_kind(trace_kind), .trace_seq(trace_seq),
    .fifo_cnt(fifo_cnt), .full(full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [1:0]  kind;
    logic [15:0] seq;
  } rec_t;

  rec_t        mq[$];
  logic [15:0] m_drop = '0;
  logic [15:0] m_seq  = '0;

  // Reference model: a plain queue updated from pre-edge inputs.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_drop = '0;
      m_seq  = '0;
    end else begin
      int  sz;
      bit  pop;
      rec_t r;
      sz  = mq.size();
      pop = (sz != 0) && trace_rdy;
      if (commit_vld) begin
        if (sz < DEPTH) begin
          r.pc    = commit_pc;
          r.instr = commit_instr;
          r.wd    = commit_wr_data;
          r.rd    = commit_rd;
          if (commit_is_r)      r.kind = 2'd1;
          else if (commit_is_i) r.kind = 2'd2;
          else                  r.kind = 2'd0;
          r.seq = SEQ_ON ? m_seq : 16'd0;
          mq.push_back(r);
        end else if (m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
        m_seq = m_seq + 16'd1;
      end
      if (pop) void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_vld", 64'(trace_vld), 64'(mq.size() != 0));
      chk("m_cnt", 64'(fifo_cnt), 64'(mq.size()));
      chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
      chk("m_drop", 64'(drop_cnt), 64'(m_drop));
      if (mq.size() != 0) begin
        chk("m_pc", 64'(trace_pc), 64'(mq[0].pc));
        chk("m_instr", 64'(trace_instr), 64'(mq[0].instr));
        chk("m_wd", 64'(trace_wr_data), 64'(mq[0].wd));
        chk("m_rd", 64'(trace_rd), 64'(mq[0].rd));
        chk("m_kind", 64'(trace_kind), 64'(mq[0].kind));
        chk("m_seq", 64'(trace_seq), 64'(mq[0].seq));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic r, input logic i);
    commit_vld     = 1'b1;
    commit_pc      = pc;
    commit_instr   = ins;
    commit_wr_data = wd;
    commit_rd      = rd;
    commit_is_r    = r;
    commit_is_i    = i;
  endtask

  initial begin
    logic [1:0] ek;
    reset = 1'b1;
    trace_rdy = 1'b0;
    commit(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    commit_vld = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk_on = 1'b1;
    chk("rst_vld", 64'(trace_vld), 64'd0);
    chk("rst_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_seq", 64'(trace_seq), 64'd0);

    // Single R-type commit
    trace_rdy = 1'b1;
    commit(32'h40, 32'h012A4020, 32'h15, 5'd8, 1'b1, 1'b0);
    cyc();
    commit_vld = 1'b0;
    chk("t1_vld", 64'(trace_vld), 64'd1);
    chk("t1_pc", 64'(trace_pc), 64'h40);
    chk("t1_instr", 64'(trace_instr), 64'h012A4020);
    chk("t1_rd", 64'(trace_rd), 64'd8);
    chk("t1_wd", 64'(trace_wr_data), 64'h15);
    chk("t1_kind", 64'(trace_kind), 64'd1);
    chk("t1_seq", 64'(trace_seq), 64'd0);
    cyc();
    chk("t1_cnt", 64'(fifo_cnt), 64'd0);

    // Fill to full, then one dropped commit
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    trace_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      commit(32'h100 + 32'(4 * i), 32'h20000000 | 32'(i),
             32'hA000 + 32'(i), 5'(i), 1'b0, 1'b1);
      cyc();
    end
    chk("t2_cnt8", 64'(fifo_cnt), 64'd8);
    chk("t2_full", 64'(full), 64'd1);
    commit(32'h1F0, 32'h2FFFFFFF, 32'hDEAD, 5'd31, 1'b0, 1'b1);
    cyc();
    commit_vld = 1'b0;
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    chk("t2_cnt_hold", 64'(fifo_cnt), 64'd8);
    trace_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_pc", 64'(trace_pc), 64'h100 + 64'(4 * i));
      chk("t2_drain_seq", 64'(trace_seq), SEQ_ON ? 64'(i) : 64'd0);
      cyc();
    end
    chk("t2_empty", 64'(fifo_cnt), 64'd0);
    trace_rdy = 1'b0;
    commit(32'h200, 32'h30000000, 32'h77, 5'd9, 1'b0, 1'b1);
    cyc();
    commit_vld = 1'b0;
    chk("t2_next_seq", 64'(trace_seq), SEQ_ON ? 64'd9 : 64'd0);
    chk("t2_next_kind", 64'(trace_kind), 64'd2);

    // Full with pop and push together: pop happens, push dropped
    for (int i = 0; i < 7; i++) begin
      commit(32'h300 + 32'(4 * i), 32'h31000000 | 32'(i),
             32'hB000 + 32'(i), 5'(i + 1), 1'b0, 1'b0);
      cyc();
    end
    chk("t3_full", 64'(full), 64'd1);
    trace_rdy = 1'b1;
    commit(32'h3F0, 32'h3FFFFFFF, 32'hBEEF, 5'd30, 1'b1, 1'b0);
    cyc();
    commit_vld = 1'b0;
    trace_rdy = 1'b0;
    chk("t3_cnt7", 64'(fifo_cnt), 64'd7);
    chk("t3_drop2", 64'(drop_cnt), 64'd2);
    chk("t3_nfull", 64'(full), 64'd0);

    // Backpressure: head stable for 3 cycles
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_hold_pc", 64'(trace_pc), 64'h300);
      chk("t4_hold_cnt", 64'(fifo_cnt), 64'd7);
    end
    trace_rdy = 1'b1;
    cyc();
    chk("t4_pop_cnt", 64'(fifo_cnt), 64'd6);
    chk("t4_pop_pc", 64'(trace_pc), 64'h304);
    for (int k = 0; k < 16 && trace_vld; k++) cyc();
    chk("t4_drained", 64'(trace_vld), 64'd0);

    // Steady stream across pointer wrap, all kind combinations
    for (int i = 0; i < 20; i++) begin
      commit(32'h1000 + 32'(4 * i), 32'h40000000 + 32'(i), 32'(i * 3),
             5'(i), (i % 4 == 1) || (i % 4 == 3), (i % 4 >= 2));
      cyc();
      case (i % 4)
        0:       ek = 2'd0;
        2:       ek = 2'd2;
        default: ek = 2'd1;
      endcase
      chk("t5_cnt", 64'(fifo_cnt), 64'd1);
      chk("t5_pc", 64'(trace_pc), 64'h1000 + 64'(4 * i));
      chk("t5_kind", 64'(trace_kind), 64'(ek));
    end
    commit_vld = 1'b0;
    cyc();
    chk("t5_cnt0", 64'(fifo_cnt), 64'd0);
    chk("t5_drop", 64'(drop_cnt), 64'd2);

    // Reset mid-stream with 5 entries held; commit during reset ignored
    trace_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      commit(32'h400 + 32'(4 * i), 32'h50000000, 32'(i), 5'(i), 1'b1, 1'b0);
      cyc();
    end
    chk("t6_cnt5", 64'(fifo_cnt), 64'd5);
    reset = 1'b1;
    cyc();
    chk("t6_vld", 64'(trace_vld), 64'd0);
    chk("t6_cnt", 64'(fifo_cnt), 64'd0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_seq", 64'(trace_seq), 64'd0);
    reset = 1'b0;
    commit(32'h500, 32'h60000000, 32'h99, 5'd3, 1'b0, 1'b0);
    cyc();
    commit_vld = 1'b0;
    chk("t6_post_pc", 64'(trace_pc), 64'h500);
    chk("t6_post_seq", 64'(trace_seq), 64'd0);
    chk("t6_post_cnt", 64'(fifo_cnt), 64'd1);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
